// File: rtl/sw_ctrl_pkg.sv
// Shared definitions for the switch-bank controller: register offsets,
// edge-capture modes, debounce history depth and the per-bit edge function.
package sw_ctrl_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_MASK   = 2'd1;
  localparam logic [1:0] REG_EDGE   = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISE = 2'd0,
    EDGE_FALL = 2'd1,
    EDGE_BOTH = 2'd2
  } edge_mode_e;

  localparam int unsigned HIST_LEN = 4;

  // Unrecognised modes fall back to rising-edge capture.
  function automatic logic edge_event(edge_mode_e mode, logic cur, logic prev);
    case (mode)
      EDGE_FALL: return ~cur & prev;
      EDGE_BOTH: return cur ^ prev;
      default:   return cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// Single-switch debounce cell: HIST_LEN-deep sample history and a hysteretic
// debounced output. Only built when SW_DEBOUNCE_EN is defined.
`ifdef SW_DEBOUNCE_EN
module sw_debounce_bit
  import sw_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic din,
  output logic deb
);

  logic [HIST_LEN-1:0] hist;
  logic [HIST_LEN-1:0] hist_next;
  logic                deb_next;

  // Decision uses the history including the sample taken on this tick.
  always_comb begin
    hist_next = {hist[HIST_LEN-2:0], din};
    deb_next  = deb;
    if (&hist_next) begin
      deb_next = 1'b1;
    end else if (~|hist_next) begin
      deb_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist <= '0;
      deb  <= 1'b0;
    end else if (tick) begin
      hist <= hist_next;
      deb  <= deb_next;
    end
  end

endmodule
`endif

// File: rtl/sw_debounce_ctrl.sv
// Avalon-MM switch-bank controller: sync, optional debounce (SW_DEBOUNCE_EN),
// sticky edge capture with W1C, maskable level interrupt.
module sw_debounce_ctrl
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH           = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE[1:0]);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d;
  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] edge_clr;
  logic [WIDTH-1:0] wdata_w;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;

  // Counts elapsed cycles rather than remaining ones so the reset value is
  // zero; the tick still lands DEBOUNCE_CYCLES after release, then every period.
  assign tick = (tick_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sw_debounce_bit u_bit (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .din     (sync2[i]),
      .deb     (deb[i])
    );
  end
`else
  logic unused_dc;

  assign deb       = sync2;
  assign unused_dc = (DEBOUNCE_CYCLES >= 2);
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d <= '0;
    end else begin
      deb_d <= deb;
    end
  end

  always_comb begin
    ev = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      ev[i] = edge_event(MODE, deb[i], deb_d[i]);
    end
  end

  assign wr_en        = chipselect & ~write_n;
  assign wdata_w      = writedata[WIDTH-1:0];
  assign unused_wdata = ^writedata;

  always_comb begin
    edge_clr = '0;
    if (wr_en && (address == REG_EDGE)) begin
      edge_clr = wdata_w;
    end
  end

  // A new event in the same cycle as its W1C keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= '0;
      edge_q <= '0;
      irq    <= 1'b0;
    end else begin
      if (wr_en && (address == REG_MASK)) begin
        mask <= wdata_w;
      end
      edge_q <= (edge_q & ~edge_clr) | ev;
      irq    <= |(edge_q & mask);
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      REG_DATA: rd_next = 32'(deb);
      REG_MASK: rd_next = 32'(mask);
      REG_EDGE: rd_next = 32'(edge_q);
      default:  rd_next = 32'({sync2, irq});
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_sw_debounce_ctrl.sv
// Directed bench for sw_debounce_ctrl: a rising-edge and a both-edge instance
// share one bus; expectations follow the SW_DEBOUNCE_EN build setting.
module tb_sw_debounce_ctrl;
  import sw_ctrl_pkg::*;

  localparam int unsigned W      = 10;
  localparam int unsigned DC     = 4;
  localparam int unsigned SETTLE = 24;
`ifdef SW_DEBOUNCE_EN
  localparam bit          DEB_ON  = 1'b1;
  localparam int unsigned LAT_MIN = 16;
  localparam int unsigned LAT_MAX = 19;
`else
  localparam bit          DEB_ON  = 1'b0;
  localparam int unsigned LAT_MIN = 3;
  localparam int unsigned LAT_MAX = 3;
`endif

  typedef struct {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rise;
    logic [31:0] exp_both;
    logic        exp_irq;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [W-1:0] in_port;
  logic [31:0]  rd_rise, rd_both;
  logic         irq_rise, irq_both;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc;
  vec_t        vecs [13];

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  sw_debounce_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_rise), .irq(irq_rise)
  );

  sw_debounce_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(2)) u_both (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rd_both), .irq(irq_both)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_irq(input string name, input logic exp);
    check({name, " irq rise"}, 32'(irq_rise), 32'(exp));
    check({name, " irq both"}, 32'(irq_both), 32'(exp));
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] a,
                          input logic [31:0] exp_rise, input logic [31:0] exp_both);
    bus_rd(a);
    check({name, " rise"}, rd_rise, exp_rise);
    check({name, " both"}, rd_both, exp_both);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned lat;
    bit          found;
    int unsigned c0;
    int unsigned first;
    int unsigned t_ev;

    vecs[0]  = '{1'b0, REG_EDGE,   32'h0,         32'h155, 32'h17D, 1'b0};
    vecs[1]  = '{1'b1, REG_MASK,   32'hFFFF_FFFF, 32'h0,   32'h0,   1'b0};
    vecs[2]  = '{1'b0, REG_MASK,   32'h0,         32'h3FF, 32'h3FF, 1'b1};
    vecs[3]  = '{1'b0, REG_STATUS, 32'h0,         32'h2AB, 32'h2AB, 1'b1};
    vecs[4]  = '{1'b1, REG_DATA,   32'hFFFF_FFFF, 32'h0,   32'h0,   1'b0};
    vecs[5]  = '{1'b0, REG_DATA,   32'h0,         32'h155, 32'h155, 1'b1};
    vecs[6]  = '{1'b1, REG_STATUS, 32'hFFFF_FFFF, 32'h0,   32'h0,   1'b0};
    vecs[7]  = '{1'b0, REG_STATUS, 32'h0,         32'h2AB, 32'h2AB, 1'b1};
    vecs[8]  = '{1'b1, REG_EDGE,   32'hFFFF_FFFF, 32'h0,   32'h0,   1'b0};
    vecs[9]  = '{1'b0, REG_EDGE,   32'h0,         32'h0,   32'h0,   1'b0};
    vecs[10] = '{1'b0, REG_STATUS, 32'h0,         32'h2AA, 32'h2AA, 1'b0};
    vecs[11] = '{1'b1, REG_MASK,   32'h0,         32'h0,   32'h0,   1'b0};
    vecs[12] = '{1'b0, REG_MASK,   32'h0,         32'h0,   32'h0,   1'b0};

    reset_n = 1'b0; in_port = '1; address = REG_DATA;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    step(3);
    check("reset readdata rise", rd_rise, 32'h0);
    check("reset readdata both", rd_both, 32'h0);
    check_irq("reset", 1'b0);

    reset_n = 1'b1;
    step(20);
    rd_check("post-reset DATA", REG_DATA, 32'h3FF, 32'h3FF);
    rd_check("post-reset EDGE", REG_EDGE, 32'h3FF, 32'h3FF);
    bus_wr(REG_EDGE, 32'hFFFF_FFFF);
    rd_check("EDGE after clear", REG_EDGE, 32'h0, 32'h0);

    // all switches released: only the both-edge instance sees the falls
    in_port = '0;
    step(SETTLE);
    rd_check("fall capture", REG_EDGE, 32'h0, 32'h3FF);
    bus_wr(REG_EDGE, 32'h3FF);

    // five-cycle glitch on bit 3
    in_port = 10'h008;
    step(5);
    in_port = '0;
    step(SETTLE);
    rd_check("glitch EDGE", REG_EDGE, DEB_ON ? 32'h0 : 32'h8, DEB_ON ? 32'h0 : 32'h8);
    rd_check("glitch DATA", REG_DATA, 32'h0, 32'h0);
    bus_wr(REG_EDGE, 32'h3FF);

    // stable press on bit 3, measure pin-to-DATA latency
    in_port = 10'h008; address = REG_DATA; chipselect = 1'b1; write_n = 1'b1;
    lat = 0; found = 1'b0;
    for (int unsigned n = 1; n <= LAT_MAX + 4 && !found; n++) begin
      @(posedge clk);
      #1;
      if (rd_rise[3]) begin
        lat = n; found = 1'b1;
      end
    end
    chipselect = 1'b0;
    n_cmp++;
    if (!found || lat < LAT_MIN || lat > LAT_MAX) begin
      n_err++;
      $display("FAIL debounce latency: got %0d cycles (found=%0d) required %0d..%0d",
               lat, found, LAT_MIN, LAT_MAX);
    end
    step(4);
    rd_check("press DATA", REG_DATA, 32'h8, 32'h8);
    rd_check("press EDGE", REG_EDGE, 32'h8, 32'h8);

    // mask gating of a pending edge
    check_irq("masked pending", 1'b0);
    bus_wr(REG_MASK, 32'h8);
    check_irq("unmask same cycle", 1'b0);
    step(1);
    check_irq("unmask +1", 1'b1);
    rd_check("STATUS with irq", REG_STATUS, 32'h11, 32'h11);
    bus_wr(REG_EDGE, 32'h8);
    check_irq("clear same cycle", 1'b1);
    step(1);
    check_irq("clear +1", 1'b0);
    rd_check("EDGE after W1C", REG_EDGE, 32'h0, 32'h0);
    bus_wr(REG_MASK, 32'h0);

    // W1C of bit 5 in the exact cycle its edge event fires
    in_port = 10'h028;
    c0 = cyc;
    if (DEB_ON) begin
      first = ((c0 + 3 + DC - 1) / DC) * DC;
      t_ev  = first + (HIST_LEN - 1) * DC;
    end else begin
      t_ev = c0 + 2;
    end
    step(t_ev - c0);
    bus_wr(REG_EDGE, 32'h20);
    rd_check("set beats clear", REG_EDGE, 32'h20, 32'h20);

    // falling edge on bit 0
    in_port = 10'h029;
    step(SETTLE);
    bus_wr(REG_EDGE, 32'h3FF);
    rd_check("EDGE before fall", REG_EDGE, 32'h0, 32'h0);
    in_port = 10'h028;
    step(SETTLE);
    rd_check("bit0 fall", REG_EDGE, 32'h0, 32'h1);

    // register map table
    in_port = 10'h155;
    step(SETTLE);
    foreach (vecs[k]) begin
      if (vecs[k].wr) begin
        bus_wr(vecs[k].addr, vecs[k].wdata);
      end else begin
        rd_check($sformatf("vec%0d", k), vecs[k].addr, vecs[k].exp_rise, vecs[k].exp_both);
        check_irq($sformatf("vec%0d", k), vecs[k].exp_irq);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sw_debounce_ctrl.md
Name: sw_debounce_ctrl

Overview:
- Avalon-MM slave controller for the 10-bit board-switch input bank on the NIOS II system bus.
- Synchronises and debounces the raw switch pins, then captures edges into a sticky register.
- Raises a maskable interrupt to the CPU, which services switches by IRQ instead of polling the raw port.
- Sits between the FPGA pins and the NIOS II interconnect, one instance per switch bank.

Parameters:
- WIDTH, 10, number of switch inputs; legal range 1..32.
- DEBOUNCE_CYCLES, 500000, clk cycles between debounce samples (10 ms at 50 MHz); must be >= 2.
- EDGE_MODE, 0, edges to capture: 0 = rising, 1 = falling, 2 = both.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  2  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  raw asynchronous switch pins
- readdata  out  32  registered read data
- irq  out  1  level interrupt to CPU

Behaviour:
- Reset and clocking: one clock; reset is asynchronous and active-low (clk, reset_n). Every flop clears to 0 on reset, including the outputs readdata and irq. The first debounce tick comes a full DEBOUNCE_CYCLES after reset release.
- Synchroniser: two flops per bit (sync1, sync2); this adds 2 cycles of latency.
- Tick prescaler: a shared down-counter loads DEBOUNCE_CYCLES-1, decrements each cycle and pulses tick for one cycle at 0, then reloads.
- Debounce sampling: on tick, each bit shifts sync2 into a 4-bit history.
  - deb[i] becomes 1 when the history is 1111 and 0 when it is 0000; otherwise it holds.
  - Worst-case latency from a stable pin change to deb is 2 + 4*DEBOUNCE_CYCLES cycles.
  - Any glitch shorter than 3 ticks never reaches deb.
- Edge detect: deb_d is deb delayed one cycle.
  - Mode 0: ev = deb & ~deb_d. Mode 1: ev = ~deb & deb_d. Mode 2: ev = deb ^ deb_d.
- Register map (byte offset = address*4):
  - 0 DATA (RO): deb, zero-extended.
  - 1 MASK (RW): irq mask, WIDTH bits.
  - 2 EDGE (R/W1C): sticky edge bits. Set when ev[i]; cleared by writing 1 to bit i.
  - 3 STATUS (RO): bit0 = irq, bits[WIDTH:1] = sync2 raw level.
- Write rules:
  - A write occurs when chipselect=1 and write_n=0; it takes effect at the next clk edge.
  - Writes to addresses 0 and 3 are ignored. writedata bits >= WIDTH are ignored.
  - EDGE set and W1C clear of the same bit in the same cycle: set wins and the bit stays 1.
- Read: readdata is registered every cycle from the address mux, giving 1-cycle read latency with no wait states. Unused upper bits read 0.
- irq: registered, irq <= |(EDGE & MASK).
  - Asserts 1 cycle after the EDGE bit sets, or 1 cycle after the MASK write that unmasks a pending bit.
  - Deasserts 1 cycle after the clear or mask write.
- Reset mid-debounce: history and deb clear, so a switch held high at reset produces a rising edge (mode 0/2) once 4 ticks have elapsed. This is intended; software clears EDGE at init.

Optional Feature:
- SW_DEBOUNCE_EN.
  - Defined: the prescaler and history logic are present as above.
  - Undefined: the prescaler and history are removed and deb = sync2 directly, giving 2-cycle latency with no glitch filtering. DEBOUNCE_CYCLES is then unused. Intended for simulation speed and for already-debounced sources.

Decomposition:
- Shared package sw_ctrl_pkg holds:
  - register offset constants: REG_DATA=0, REG_MASK=1, REG_EDGE=2, REG_STATUS=3;
  - an edge_mode enum: EDGE_RISE, EDGE_FALL, EDGE_BOTH;
  - the history depth constant HIST_LEN=4.
- One natural sub-module, sw_debounce_bit: a per-bit history shifter plus deb flop, instantiated WIDTH times under a generate and driven by the shared tick.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4 and WIDTH=10 throughout.
- Reset: hold reset_n=0 with in_port=0x3FF -> readdata=0 and irq=0. Release reset and wait 20 cycles -> DATA reads 0x3FF and EDGE reads 0x3FF (mode 0).
- Debounce: toggle in_port[3] for 5 cycles, then return it -> DATA bit3 never changes and EDGE stays 0. Then hold in_port[3]=1 -> DATA=0x008 within 2+16 cycles and EDGE=0x008.
- IRQ masking: with EDGE=0x008 pending and MASK=0, irq=0. Write MASK=0x008 -> irq=1 one cycle later. Write EDGE=0x008 -> irq=0 one cycle later.
- Set/clear collision: schedule an EDGE W1C of bit5 in the exact cycle ev[5] pulses -> EDGE bit5 reads 1 afterwards.
- Mode 2: fall in_port[0] 1->0 with EDGE_MODE=2 -> EDGE bit0 sets. In mode 0 the same stimulus leaves EDGE=0.
- Register map: read address 3 with in_port=0x155 after sync -> STATUS bits[10:1]=0x155. Write 0xFFFFFFFF to DATA -> DATA is unchanged.
